// File: rtl/pe_array_drain_ctrl.sv
// Drain sequencer for the PE array ACCFIFOs.
// Each entry is one LOAD beat, which copies every PE's ACCFIFO head into its
// output register. It is followed by NUM_PE_COL/2 SHIFT beats, which move the
// column pairs right along the out_to_right chain toward the output buffer.
// The data path lives in the PEs. This block only drives the PE control
// strobes and the buffer handshake: valid, address and column pair.
module pe_array_drain_ctrl #(
    parameter int NUM_PE_ROW   = 1,
    parameter int NUM_PE_COL   = 2,
    parameter int TOTAL_NUM_PE = NUM_PE_ROW * NUM_PE_COL,
    parameter int MAX_ENTRIES  = 16,
    parameter int ENTRY_W      = $clog2(MAX_ENTRIES + 1),
    parameter int ADDR_W       = ($clog2(MAX_ENTRIES * NUM_PE_COL / 2) > 0) ?
                                 $clog2(MAX_ENTRIES * NUM_PE_COL / 2) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ENTRY_W-1:0]              n_entries,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    input  logic [TOTAL_NUM_PE-1:0]         pe_ctrl_ACCFIFO_empty,
    output logic [TOTAL_NUM_PE-1:0]         pe_ctrl_ACCFIFO_read_to_outbuffer,
    output logic [TOTAL_NUM_PE-1:0]         pe_ctrl_out_mux_sel_PE,
    output logic [TOTAL_NUM_PE-1:0]         pe_ctrl_out_to_right_pe_en,
    output logic                            ob_valid,
    input  logic                            ob_ready,
    output logic [ADDR_W-1:0]               ob_addr,
    output logic [$clog2(NUM_PE_COL/2):0]   ob_col_pair
);

    localparam int HALF   = NUM_PE_COL / 2;
    localparam int BEAT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CP_W   = $clog2(HALF) + 1;
    localparam int SUM_W  = ENTRY_W + CP_W + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(HALF - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state;
    logic [ENTRY_W-1:0]  n_lat;
    logic [ENTRY_W-1:0]  entry;
    logic [BEAT_W-1:0]   beat;
    logic                any_empty;
    logic                last_beat;
    logic                last_entry;
    logic                rd_all;
    logic                mux_all;
    logic                en_all;

    // Clamp an oversized drain request to the ACCFIFO depth
    function automatic logic [ENTRY_W-1:0] sat_entries(input logic [ENTRY_W-1:0] n);
        return (n > ENTRY_W'(MAX_ENTRIES)) ? ENTRY_W'(MAX_ENTRIES) : n;
    endfunction

    assign any_empty  = |pe_ctrl_ACCFIFO_empty;
    assign last_beat  = (beat == LAST_BEAT);
    assign last_entry = ((entry + ENTRY_W'(1)) == n_lat);

    // Drain FSM with registered busy/done/ob_valid; abort overrides every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_lat    <= '0;
            entry    <= '0;
            beat     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ob_valid <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            entry    <= '0;
            beat     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ob_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= sat_entries(n_entries);
                        err   <= 1'b0;
                        entry <= '0;
                        beat  <= '0;
                        busy  <= 1'b1;
                        if (n_entries == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (any_empty) begin
                        // A missing head would corrupt the entry; give up without done
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= SHIFT;
                        beat     <= '0;
                        ob_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ob_ready) begin
                        if (!last_beat) begin
                            beat <= beat + BEAT_W'(1);
                        end else begin
                            beat     <= '0;
                            ob_valid <= 1'b0;
                            if (last_entry) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                entry <= entry + ENTRY_W'(1);
                                state <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // PE strobes follow the current state and ob_ready so that a stall freezes the chain the same cycle
    always_comb begin
        rd_all  = 1'b0;
        mux_all = 1'b0;
        en_all  = 1'b0;
        case (state)
            LOAD: begin
                if (!any_empty) begin
                    rd_all = 1'b1;
                    en_all = 1'b1;
                end
            end
            SHIFT: begin
                // The last beat has already reached the rightmost pair, so it is not shifted
                if (ob_ready && !last_beat) begin
                    mux_all = 1'b1;
                    en_all  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign pe_ctrl_ACCFIFO_read_to_outbuffer = {TOTAL_NUM_PE{rd_all}};
    assign pe_ctrl_out_mux_sel_PE            = {TOTAL_NUM_PE{mux_all}};
    assign pe_ctrl_out_to_right_pe_en        = {TOTAL_NUM_PE{en_all}};

    assign ob_addr     = ob_valid ? ADDR_W'(SUM_W'(entry) * SUM_W'(HALF) + SUM_W'(beat)) : '0;
    assign ob_col_pair = ob_valid ? (CP_W'(HALF - 1) - CP_W'(beat)) : '0;

endmodule

// File: tb/tb_pe_array_drain_ctrl.sv
// Bench for pe_array_drain_ctrl at a 2x4 PE array with 16-entry ACCFIFOs.
module tb_pe_array_drain_ctrl;

    localparam int R   = 2;
    localparam int C   = 4;
    localparam int M   = 16;
    localparam int T   = R * C;
    localparam int EW  = 5;
    localparam int AW  = 5;
    localparam int CPW = 2;
    localparam int H   = C / 2;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [EW-1:0]  n_entries;
    logic           abort;
    logic           busy;
    logic           done;
    logic           err;
    logic [T-1:0]   empty;
    logic [T-1:0]   rd;
    logic [T-1:0]   mux;
    logic [T-1:0]   en;
    logic           ob_valid;
    logic           ob_ready;
    logic [AW-1:0]  ob_addr;
    logic [CPW-1:0] ob_col_pair;

    int n_tests = 0;
    int n_fail  = 0;

    pe_array_drain_ctrl #(
        .NUM_PE_ROW  (R),
        .NUM_PE_COL  (C),
        .MAX_ENTRIES (M)
    ) dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .start                             (start),
        .n_entries                         (n_entries),
        .abort                             (abort),
        .busy                              (busy),
        .done                              (done),
        .err                               (err),
        .pe_ctrl_ACCFIFO_empty             (empty),
        .pe_ctrl_ACCFIFO_read_to_outbuffer (rd),
        .pe_ctrl_out_mux_sel_PE            (mux),
        .pe_ctrl_out_to_right_pe_en        (en),
        .ob_valid                          (ob_valid),
        .ob_ready                          (ob_ready),
        .ob_addr                           (ob_addr),
        .ob_col_pair                       (ob_col_pair)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           start;
        logic [EW-1:0]  n;
        logic           ready;
        logic           abort;
        logic [T-1:0]   empty;
        logic           busy;
        logic           done;
        logic           err;
        logic           valid;
        logic [AW-1:0]  addr;
        logic [CPW-1:0] col;
        logic           rd;
        logic           mux;
        logic           en;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input int n, input logic rdy, input logic ab,
                                input logic [T-1:0] emp, input logic b, input logic d,
                                input logic e, input logic v, input int a, input int cp,
                                input logic r, input logic m, input logic pen);
        vec_t x;
        x.start = s;   x.n = EW'(n);    x.ready = rdy;   x.abort = ab;  x.empty = emp;
        x.busy  = b;   x.done = d;      x.err = e;       x.valid = v;
        x.addr  = AW'(a); x.col = CPW'(cp);
        x.rd    = r;   x.mux = m;       x.en = pen;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_now();
        return 64'({busy, done, err, ob_valid, ob_addr, ob_col_pair, rd, mux, en});
    endfunction

    task automatic apply_table();
        for (int i = 0; i < vecs.size(); i++) begin
            logic [63:0] exp;
            @(negedge clk);
            start     = vecs[i].start;
            n_entries = vecs[i].n;
            ob_ready  = vecs[i].ready;
            abort     = vecs[i].abort;
            empty     = vecs[i].empty;
            #1;
            exp = 64'({vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].valid, vecs[i].addr,
                       vecs[i].col, {T{vecs[i].rd}}, {T{vecs[i].mux}}, {T{vecs[i].en}}});
            check($sformatf("vec%0d", i), outs_now(), exp);
        end
    endtask

    // Reference: the drain is a list of n*H buffer beats in address order,
    // each entry costs one load cycle plus H accepted beats, stalls add cycles.
    task automatic run_drain(input int n, input int rdy_pct, input string tag);
        int nsat, stalls, hs, rd_c, en_c, mux_c, done_c, done_at, bad_eq, last_addr;
        int exp_addr[$];
        int exp_col[$];
        bit finished;
        nsat = (n > M) ? M : n;
        for (int e = 0; e < nsat; e++)
            for (int b = 0; b < H; b++) begin
                exp_addr.push_back(e * H + b);
                exp_col.push_back(H - 1 - b);
            end
        stalls = 0; hs = 0; rd_c = 0; en_c = 0; mux_c = 0;
        done_c = 0; done_at = -1; bad_eq = 0; last_addr = -1; finished = 0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            @(negedge clk);
            start     = (k == 0);
            n_entries = (k == 0) ? EW'(n) : '0;
            ob_ready  = ($urandom_range(99) < rdy_pct);
            abort     = 1'b0;
            empty     = '0;
            #1;
            if ((rd != '0 && rd != '1) || (mux != '0 && mux != '1) || (en != '0 && en != '1))
                bad_eq++;
            if (rd[0])  rd_c++;
            if (en[0])  en_c++;
            if (mux[0]) mux_c++;
            if (ob_valid) begin
                if (ob_ready) begin
                    if (exp_addr.size() == 0) begin
                        check({tag, "_extra_beat"}, 64'(1), 64'(0));
                    end else begin
                        check($sformatf("%s_addr%0d", tag, hs), 64'(ob_addr), 64'(exp_addr[0]));
                        check($sformatf("%s_col%0d", tag, hs), 64'(ob_col_pair), 64'(exp_col[0]));
                        void'(exp_addr.pop_front());
                        void'(exp_col.pop_front());
                    end
                    last_addr = int'(ob_addr);
                    hs++;
                end else begin
                    stalls++;
                end
            end
            if (done) begin
                done_c++;
                done_at = k;
            end
            if (done_at >= 0 && !busy) finished = 1;
        end
        check({tag, "_finished"}, 64'(finished), 64'(1));
        check({tag, "_beats"}, 64'(hs), 64'(nsat * H));
        check({tag, "_done_count"}, 64'(done_c), 64'(1));
        check({tag, "_done_cycle"}, 64'(done_at), 64'(1 + nsat * (1 + H) + stalls));
        check({tag, "_loads"}, 64'(rd_c), 64'(nsat));
        check({tag, "_enables"}, 64'(en_c), 64'(nsat * H));
        check({tag, "_shifts"}, 64'(mux_c), 64'(nsat * (H - 1)));
        check({tag, "_bits_equal"}, 64'(bad_eq), 64'(0));
        if (nsat > 0)
            check({tag, "_last_addr"}, 64'(last_addr), 64'(nsat * H - 1));
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; n_entries = '0; abort = 1'b0;
        empty = '0; ob_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", outs_now(), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // plain n=2 drain
        vecs.push_back(mk(1,2,1,0,0, 0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,0,1,0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,2,1,0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,3,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,0,0,0,0,0,0,0,0));
        // backpressure for 3 cycles at beat 0
        vecs.push_back(mk(1,2,1,0,0, 0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,0,1,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,0,1,0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,2,1,0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,3,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,0,0,0,0,0,0,0,0));
        // empty ACCFIFO on the second load, then n=0 clears err
        vecs.push_back(mk(1,2,1,0,0, 0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,0,1,0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,8'h20, 1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0,0, 0,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,0,0,0,0,0,0,0,0));
        // abort at entry 1 beat 0, restart with n=1 right after
        vecs.push_back(mk(1,2,1,0,0, 0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,0,1,0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,1,0, 1,0,0,1,2,1,0,1,1));
        vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,0,1,0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,0,0,0,0,0,0,0,0));
        apply_table();

        // saturation: 20 requested, 16 drained
        run_drain(20, 100, "sat");

        // reset asserted in the middle of a LOAD
        @(negedge clk);
        start = 1'b1; n_entries = EW'(2); ob_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; n_entries = '0;
        #1 check("rst_in_load_pre", 64'({busy, rd[0], en[0]}), 64'(3'b111));
        #1 rst_n = 1'b0;
        #1 check("rst_in_load_outputs", outs_now(), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_drain(2, 100, "after_rst");

        // randomized drains with random backpressure
        for (int t = 0; t < 20; t++)
            run_drain($urandom_range(0, 20), $urandom_range(40, 100), $sformatf("rnd%0d", t));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
